// File: rtl/spi_reg_pkg.sv
// ============================================================================
// Module  : spi_reg_pkg
// Purpose : Shared register-map constants and decode types for spi_reg_bank.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

package spi_reg_pkg;

    localparam int unsigned IDX_ID      = 0;
    localparam int unsigned IDX_STATUS  = 1;
    localparam int unsigned IDX_RW_BASE = 2;
    localparam int unsigned ERR_CNT_W   = 8;

    // Classification of one frame-end event.
    typedef enum logic [1:0] {
        ACC_NONE    = 2'd0,
        ACC_WRITE   = 2'd1,
        ACC_READ    = 2'd2,
        ACC_ILLEGAL = 2'd3
    } acc_e;

endpackage : spi_reg_pkg

`default_nettype wire

// File: rtl/spi_edge_det.sv
// ============================================================================
// Module  : spi_edge_det
// Purpose : Rising-edge detector; history flop resets high so a level that is
//           already asserted at reset release yields no edge.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module spi_edge_det (
    input  logic clk,
    input  logic rst_n,
    input  logic d_i,
    output logic rise_o
);

    logic hist_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hist_q <= 1'b1;
        end else begin
            hist_q <= d_i;
        end
    end

    assign rise_o = d_i & ~hist_q;

endmodule : spi_edge_det

`default_nettype wire

// File: rtl/spi_reg_bank.sv
// ============================================================================
// Module  : spi_reg_bank
// Purpose : SPI-attached register bank: ID, sticky STATUS, RW registers and a
//           saturating illegal-access counter.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module spi_reg_bank
    import spi_reg_pkg::*;
#(
    parameter int                    DATA_WIDTH = 16,
    parameter int                    ADDR_WIDTH = 8,
    parameter int unsigned           NUM_RW     = 4,
    parameter logic [DATA_WIDTH-1:0] ID_VALUE   = 16'h0AD0,
    parameter logic [DATA_WIDTH-1:0] RW_RESET   = '0
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic [ADDR_WIDTH-1:0]        addr,
    input  logic                         txreq,
    input  logic                         spi_over,
    input  logic [DATA_WIDTH-1:0]        rxdata,
    output logic [DATA_WIDTH-1:0]        txdata,
    input  logic [DATA_WIDTH-1:0]        stat_in,
    output logic [NUM_RW*DATA_WIDTH-1:0] reg_q,
    output logic [NUM_RW-1:0]            wr_pulse,
    output logic [ERR_CNT_W-1:0]         err_cnt
);

    logic                  over_rise;
    logic [31:0]           idx;
    logic                  idx_rw;
    logic                  idx_mapped;
    acc_e                  acc;
    logic [DATA_WIDTH-1:0] rw_q [NUM_RW];
    logic [NUM_RW-1:0]     wr_pulse_q;
    logic [DATA_WIDTH-1:0] status_q;
    logic [DATA_WIDTH-1:0] status_d;
    logic                  clr_q;
    logic [ERR_CNT_W-1:0]  err_cnt_q;
    logic [DATA_WIDTH-1:0] txdata_q;
    logic [DATA_WIDTH-1:0] rd_mux;
    logic                  unused_rw_flag;

    spi_edge_det u_over_edge (
        .clk    (clk),
        .rst_n  (rst_n),
        .d_i    (spi_over),
        .rise_o (over_rise)
    );

    // The address MSB carries the SPI rw flag; direction comes from txreq only.
    assign unused_rw_flag = addr[ADDR_WIDTH-1];
    assign idx            = 32'(addr[ADDR_WIDTH-2:0]);
    assign idx_rw         = (idx >= IDX_RW_BASE) && (idx < IDX_RW_BASE + NUM_RW);
    assign idx_mapped     = (idx <= IDX_RW_BASE + NUM_RW);

    always_comb begin
        acc = ACC_NONE;
        if (over_rise) begin
            if (txreq) begin
                acc = idx_mapped ? ACC_READ : ACC_ILLEGAL;
            end else begin
                acc = idx_rw ? ACC_WRITE : ACC_ILLEGAL;
            end
        end
    end

    for (genvar k = 0; k < int'(NUM_RW); k++) begin : g_rw
        logic sel;
        assign sel = (acc == ACC_WRITE) && (idx == IDX_RW_BASE + unsigned'(k));

        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                rw_q[k]       <= RW_RESET;
                wr_pulse_q[k] <= 1'b0;
            end else begin
                wr_pulse_q[k] <= sel;
                if (sel) begin
                    rw_q[k] <= rxdata;
                end
            end
        end

        assign reg_q[k*DATA_WIDTH +: DATA_WIDTH] = rw_q[k];
    end

    // The clear lands one cycle after the read event; new events still set.
    always_comb begin
        status_d = status_q;
        if (clr_q) begin
            status_d = '0;
        end
        status_d = status_d | stat_in;
    end

    always_comb begin
        rd_mux = '0;
        if (idx == IDX_ID) begin
            rd_mux = ID_VALUE;
        end else if (idx == IDX_STATUS) begin
            rd_mux = status_q;
        end else if (idx == IDX_RW_BASE + NUM_RW) begin
            rd_mux = DATA_WIDTH'(err_cnt_q);
        end else begin
            for (int unsigned k = 0; k < NUM_RW; k++) begin
                if (idx == IDX_RW_BASE + k) begin
                    rd_mux = rw_q[k];
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            status_q  <= '0;
            clr_q     <= 1'b0;
            err_cnt_q <= '0;
            txdata_q  <= '0;
        end else begin
            status_q <= status_d;
            clr_q    <= (acc == ACC_READ) && (idx == IDX_STATUS);
            if ((acc == ACC_ILLEGAL) && (err_cnt_q != '1)) begin
                err_cnt_q <= err_cnt_q + ERR_CNT_W'(1);
            end
            if (!spi_over) begin
                txdata_q <= rd_mux;
            end
        end
    end

    assign txdata   = txdata_q;
    assign wr_pulse = wr_pulse_q;
    assign err_cnt  = err_cnt_q;

endmodule : spi_reg_bank

`default_nettype wire

// File: tb/tb_spi_reg_bank.sv
// ============================================================================
// Module  : tb_spi_reg_bank
// Purpose : Randomized self-checking bench for spi_reg_bank with a
//           transaction-level register-map model.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_spi_reg_bank;

    localparam int          DW     = 16;
    localparam int          AW     = 8;
    localparam int          NRW    = 4;
    localparam logic [15:0] ID_VAL = 16'h0AD0;

    logic             clk = 1'b0;
    logic             rst_n = 1'b0;
    logic [AW-1:0]    addr = '0;
    logic             txreq = 1'b0;
    logic             spi_over = 1'b0;
    logic [DW-1:0]    rxdata = '0;
    logic [DW-1:0]    txdata;
    logic [DW-1:0]    stat_in = '0;
    logic [NRW*DW-1:0] reg_q;
    logic [NRW-1:0]   wr_pulse;
    logic [7:0]       err_cnt;

    spi_reg_bank #(
        .DATA_WIDTH (DW),
        .ADDR_WIDTH (AW),
        .NUM_RW     (NRW),
        .ID_VALUE   (ID_VAL),
        .RW_RESET   (16'h0000)
    ) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .addr     (addr),
        .txreq    (txreq),
        .spi_over (spi_over),
        .rxdata   (rxdata),
        .txdata   (txdata),
        .stat_in  (stat_in),
        .reg_q    (reg_q),
        .wr_pulse (wr_pulse),
        .err_cnt  (err_cnt)
    );

    always #5 clk = ~clk;

    int n_chk  = 0;
    int n_pass = 0;

    // Reference model: contents of the register map as seen by software.
    logic [15:0] m_mem [NRW];
    logic [15:0] m_status;
    int          m_err;

    int pulse_tot [NRW];
    initial for (int b = 0; b < NRW; b++) pulse_tot[b] = 0;
    always @(negedge clk) begin
        for (int b = 0; b < NRW; b++) if (wr_pulse[b]) pulse_tot[b]++;
    end

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", tag, got, exp);
    endtask

    function automatic logic [15:0] model_read(input int idx);
        if (idx == 0) return ID_VAL;
        if (idx == 1) return m_status;
        if (idx >= 2 && idx < 2 + NRW) return m_mem[idx-2];
        if (idx == 2 + NRW) return 16'(m_err);
        return 16'h0000;
    endfunction

    function automatic logic [63:0] model_regs();
        logic [63:0] v;
        for (int k = 0; k < NRW; k++) v[k*16 +: 16] = m_mem[k];
        return v;
    endfunction

    task automatic model_reset();
        for (int k = 0; k < NRW; k++) m_mem[k] = 16'h0000;
        m_status = 16'h0000;
        m_err    = 0;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic stat_pulse(input logic [15:0] v);
        tick();
        stat_in = v;
        tick();
        stat_in = '0;
        m_status = m_status | v;
    endtask

    // One SPI frame: set up address with spi_over low, then hold high len cycles.
    task automatic frame(input logic [7:0] a, input logic t, input logic [15:0] d,
                         input int len, input logic [15:0] stat_t, input logic [15:0] stat_mid);
        int          idx;
        logic [15:0] exp_tx;
        int          snap [NRW];
        logic [31:0] got_p, exp_p;
        idx = int'(a[6:0]);
        tick();
        addr = a; txreq = t; rxdata = d; spi_over = 1'b0; stat_in = '0;
        tick();
        tick();
        exp_tx = model_read(idx);
        chk("txdata_pre", 64'(txdata), 64'(exp_tx));
        for (int b = 0; b < NRW; b++) snap[b] = pulse_tot[b];
        spi_over = 1'b1;
        stat_in  = stat_t;
        tick();
        stat_in = stat_mid;
        if (len == 1) spi_over = 1'b0;
        tick();
        stat_in = '0;
        for (int i = 2; i < len; i++) tick();
        if (len >= 2) chk("txdata_hold", 64'(txdata), 64'(exp_tx));
        spi_over = 1'b0;

        exp_p = '0;
        if (!t) begin
            if (idx >= 2 && idx < 2 + NRW) begin
                m_mem[idx-2] = d;
                exp_p[(idx-2)*8 +: 8] = 8'd1;
            end else if (m_err < 255) begin
                m_err++;
            end
            m_status = m_status | stat_t | stat_mid;
        end else begin
            if (idx > 2 + NRW && m_err < 255) m_err++;
            if (idx == 1) m_status = stat_mid;
            else m_status = m_status | stat_t | stat_mid;
        end

        tick();
        tick();
        chk("reg_q", reg_q, model_regs());
        chk("err_cnt", 64'(err_cnt), 64'(m_err));
        got_p = '0;
        for (int b = 0; b < NRW; b++) got_p[b*8 +: 8] = 8'(pulse_tot[b] - snap[b]);
        chk("wr_pulse_cnt", 64'(got_p), 64'(exp_p));
    endtask

    task automatic chk_reset_outputs(input string tag);
        chk({tag, "_txdata"}, 64'(txdata), 64'h0);
        chk({tag, "_reg_q"}, reg_q, 64'h0);
        chk({tag, "_wr_pulse"}, 64'(wr_pulse), 64'h0);
        chk({tag, "_err_cnt"}, 64'(err_cnt), 64'h0);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [15:0] r_d, r_st, r_sm;
        logic [7:0]  r_a;
        logic        r_t;
        int          r_idx;
        int          snap [NRW];
        logic [31:0] got_p;

        model_reset();

        // Reset held with a write frame already in progress.
        addr = 8'h03; txreq = 1'b0; rxdata = 16'hBEEF; spi_over = 1'b1;
        #23;
        chk_reset_outputs("rst");
        for (int b = 0; b < NRW; b++) snap[b] = pulse_tot[b];
        rst_n = 1'b1;
        repeat (4) tick();
        chk("rst_hold_reg1", 64'(reg_q[31:16]), 64'h0);
        chk("rst_hold_err", 64'(err_cnt), 64'h0);
        got_p = '0;
        for (int b = 0; b < NRW; b++) got_p[b*8 +: 8] = 8'(pulse_tot[b] - snap[b]);
        chk("rst_hold_pulse", 64'(got_p), 64'h0);
        spi_over = 1'b0;
        repeat (2) tick();

        // Basic write, ID read with hold, sticky status and set-wins clear.
        frame(8'h02, 1'b0, 16'h1234, 3, 16'h0, 16'h0);
        chk("wr_reg0", 64'(reg_q[15:0]), 64'h1234);
        frame(8'h80, 1'b1, 16'h5555, 3, 16'h0, 16'h0);
        stat_pulse(16'h0005);
        frame(8'h01, 1'b1, 16'h0, 2, 16'h0, 16'h0);
        frame(8'h01, 1'b1, 16'h0, 2, 16'h0, 16'h0004);
        frame(8'h81, 1'b1, 16'h0, 1, 16'h0, 16'h0);

        // Illegal write to ID, then saturating illegal reads.
        frame(8'h00, 1'b0, 16'hFFFF, 2, 16'h0, 16'h0);
        chk("err_after_id_wr", 64'(err_cnt), 64'd1);
        for (int i = 0; i < 300; i++) frame(8'h7F, 1'b1, 16'h0, 1, 16'h0, 16'h0);
        chk("err_saturated", 64'(err_cnt), 64'd255);
        frame(8'h00, 1'b1, 16'h0, 2, 16'h0, 16'h0);

        // Randomized traffic across the full index range.
        for (int i = 0; i < 200; i++) begin
            r_idx = $urandom_range(0, 9);
            if (r_idx == 9) r_idx = $urandom_range(7, 127);
            r_a  = {1'($urandom_range(0, 1)), 7'(r_idx)};
            r_t  = 1'($urandom_range(0, 1));
            r_d  = 16'($urandom);
            r_st = ($urandom_range(0, 3) == 0) ? 16'($urandom) : 16'h0;
            r_sm = ($urandom_range(0, 3) == 0) ? 16'($urandom) : 16'h0;
            if (r_t && r_idx == 1) r_st = 16'h0;
            if ($urandom_range(0, 4) == 0) stat_pulse(16'($urandom));
            frame(r_a, r_t, r_d, $urandom_range(1, 4), r_st, r_sm);
        end

        // Make sure state is non-trivial, then reset in the middle of a frame.
        frame(8'h03, 1'b0, 16'hA5A5, 2, 16'h0, 16'h0);
        stat_pulse(16'h8001);
        tick();
        addr = 8'h02; txreq = 1'b0; rxdata = 16'hFFFF; spi_over = 1'b1;
        tick();
        #2 rst_n = 1'b0;
        #1 chk_reset_outputs("midrst");
        tick();
        rst_n = 1'b1;
        for (int b = 0; b < NRW; b++) snap[b] = pulse_tot[b];
        repeat (2) tick();
        spi_over = 1'b0;
        repeat (3) tick();
        model_reset();
        chk("midrst_reg_q", reg_q, 64'h0);
        chk("midrst_err", 64'(err_cnt), 64'h0);
        got_p = '0;
        for (int b = 0; b < NRW; b++) got_p[b*8 +: 8] = 8'(pulse_tot[b] - snap[b]);
        chk("midrst_pulse", 64'(got_p), 64'h0);
        frame(8'h01, 1'b1, 16'h0, 2, 16'h0, 16'h0);
        frame(8'h06, 1'b1, 16'h0, 2, 16'h0, 16'h0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule : tb_spi_reg_bank

`default_nettype wire
